// File: rtl/cmd_queue_mgr.sv
// cmd_queue_mgr: queued station-route command manager for the follower robot.
// Optional piezo buzzer built when CMD_QUEUE_BUZZER_EN is defined.
module cmd_queue_mgr #(
  parameter int ID_W      = 6,
  parameter int DEPTH     = 4,
  parameter int BUZZ_HALF = 12500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ID_W+1:0]            cmd,
  input  logic                       cmd_rdy,
  input  logic [ID_W-1:0]            ID,
  input  logic                       ID_vld,
  input  logic                       OK2Move,
  output logic                       clr_cmd_rdy,
  output logic                       clr_ID_vld,
  output logic                       go,
  output logic                       in_transit,
  output logic                       arrived,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       q_full,
  output logic                       buzz,
  output logic                       buzz_n
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRANSIT,
    S_MATCH
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0] mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [ID_W-1:0] cap_id;
  logic [ID_W-1:0] head;
  logic [1:0]      opc;
  logic [ID_W-1:0] dest;
  logic            q_empty;
  logic            cmd_take, id_take;
  logic            do_flush, do_push, do_pop;
  logic            do_cap, do_arr;

  assign opc     = cmd[ID_W+1:ID_W];
  assign dest    = cmd[ID_W-1:0];
  assign head    = mem[rd_ptr];
  assign q_empty = (q_count == '0);
  assign q_full  = (q_count == CW'(DEPTH));
  assign go      = OK2Move & in_transit;

  // Requests seen during their own clear pulse are stale; commands beat IDs.
  assign cmd_take = cmd_rdy & ~clr_cmd_rdy & (state != S_MATCH);
  assign id_take  = ID_vld & ~clr_ID_vld & ~cmd_take & (state != S_MATCH);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and queue-operation decode
  always_comb begin
    state_nxt = state;
    do_flush  = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_cap    = 1'b0;
    do_arr    = 1'b0;
    case (state)
      S_IDLE, S_TRANSIT: begin
        if (cmd_take) begin
          case (opc)
            2'b00: begin
              do_flush  = 1'b1;
              state_nxt = S_IDLE;
            end
            2'b01: begin
              do_flush  = 1'b1;
              do_push   = 1'b1;
              state_nxt = S_TRANSIT;
            end
            2'b10: begin
              if (!q_full) begin
                do_push   = 1'b1;
                state_nxt = S_TRANSIT;
              end
            end
            default: begin
              if (!q_empty) begin
                do_pop = 1'b1;
                if (q_count == CW'(1)) state_nxt = S_IDLE;
              end
            end
          endcase
        end else if (id_take && state == S_TRANSIT) begin
          do_cap    = 1'b1;
          state_nxt = S_MATCH;
        end
      end
      S_MATCH: begin
        state_nxt = S_TRANSIT;
        if (!q_empty && cap_id == head) begin
          do_pop = 1'b1;
          do_arr = 1'b1;
          if (q_count == CW'(1)) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; a GOTO rewrites slot 0 after the flush
  always_ff @(posedge clk) begin
    if (do_push) mem[do_flush ? '0 : wr_ptr] <= dest;
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else if (do_flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= do_push ? PW'(1) : '0;
      q_count <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      q_count <= q_count + CW'(1);
      else if (do_pop && !do_push) q_count <= q_count - CW'(1);
    end
  end

  // Registered handshake pulses, arrival pulse and transit flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cmd_rdy <= 1'b0;
      clr_ID_vld  <= 1'b0;
      arrived     <= 1'b0;
      in_transit  <= 1'b0;
      cap_id      <= '0;
    end else begin
      clr_cmd_rdy <= cmd_take;
      clr_ID_vld  <= id_take;
      arrived     <= do_arr;
      in_transit  <= (state_nxt != S_IDLE);
      if (do_cap) cap_id <= ID;
    end
  end

`ifdef CMD_QUEUE_BUZZER_EN
  localparam int BW = $clog2(BUZZ_HALF+1);

  logic [BW-1:0] buzz_cnt;
  logic          buzz_q;
  logic          buzz_act;

  assign buzz_act = in_transit & ~OK2Move;
  assign buzz     = buzz_act & buzz_q;
  assign buzz_n   = buzz_act & ~buzz_q;

  // Half-period counter toggles the piezo while blocked in transit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buzz_cnt <= '0;
      buzz_q   <= 1'b0;
    end else if (!buzz_act) begin
      buzz_cnt <= '0;
      buzz_q   <= 1'b0;
    end else if (buzz_cnt == BW'(BUZZ_HALF-1)) begin
      buzz_cnt <= '0;
      buzz_q   <= ~buzz_q;
    end else begin
      buzz_cnt <= buzz_cnt + BW'(1);
    end
  end
`else
  assign buzz   = 1'b0;
  assign buzz_n = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_queue_mgr.sv
// tb_cmd_queue_mgr: directed self-checking bench for cmd_queue_mgr.
// DEPTH=4, ID_W=6, BUZZ_HALF=4.
module tb_cmd_queue_mgr;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic [5:0] ID;
  logic       ID_vld;
  logic       OK2Move;
  logic       clr_cmd_rdy, clr_ID_vld, go, in_transit, arrived;
  logic [2:0] q_count;
  logic       q_full, buzz, buzz_n;

  int checks = 0;
  int fails  = 0;

  cmd_queue_mgr #(.ID_W(6), .DEPTH(4), .BUZZ_HALF(4)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .ID(ID), .ID_vld(ID_vld), .OK2Move(OK2Move),
    .clr_cmd_rdy(clr_cmd_rdy), .clr_ID_vld(clr_ID_vld),
    .go(go), .in_transit(in_transit), .arrived(arrived),
    .q_count(q_count), .q_full(q_full),
    .buzz(buzz), .buzz_n(buzz_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic exp_tr,
                          input logic [2:0] exp_q);
    cmd = c;
    cmd_rdy = 1'b1;
    @(negedge clk);
    chk("clr_cmd_rdy_hi", clr_cmd_rdy, 1);
    chk("cmd_in_transit", in_transit, exp_tr);
    chk("cmd_q_count", q_count, exp_q);
    cmd_rdy = 1'b0;
    @(negedge clk);
    chk("clr_cmd_rdy_lo", clr_cmd_rdy, 0);
  endtask

  task automatic send_id(input logic [5:0] id);
    ID = id;
    ID_vld = 1'b1;
    @(negedge clk);
    chk("clr_ID_vld_hi", clr_ID_vld, 1);
    ID_vld = 1'b0;
  endtask

  task automatic after_id(input logic exp_arr, input logic [2:0] exp_q,
                          input logic exp_tr);
    @(negedge clk);
    chk("arrived", arrived, exp_arr);
    chk("clr_ID_vld_lo", clr_ID_vld, 0);
    chk("id_q_count", q_count, exp_q);
    chk("id_in_transit", in_transit, exp_tr);
    @(negedge clk);
    chk("arrived_lo", arrived, 0);
  endtask

  initial begin
    int toggles;
    logic prev;
    rst = 1'b1;
    cmd = '0;
    cmd_rdy = 1'b0;
    ID = '0;
    ID_vld = 1'b0;
    OK2Move = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_q_count", q_count, 0);
    chk("rst_in_transit", in_transit, 0);
    chk("rst_go", go, 0);
    chk("rst_clr_cmd", clr_cmd_rdy, 0);
    chk("rst_clr_id", clr_ID_vld, 0);
    chk("rst_arrived", arrived, 0);
    chk("rst_q_full", q_full, 0);
    rst = 1'b0;
    @(negedge clk);

    // GOTO 5 then arrive at 5
    send_cmd(8'h45, 1, 1);
    chk("goto_go", go, 1);
    send_id(6'd5);
    chk("match_in_transit", in_transit, 1);
    after_id(1, 0, 0);
    chk("idle_go", go, 0);

    // APPEND 3,7,9 then IDs 4,3,7,9
    send_cmd(8'h83, 1, 1);
    send_cmd(8'h87, 1, 2);
    send_cmd(8'h89, 1, 3);
    send_id(6'd4);
    after_id(0, 3, 1);
    send_id(6'd3);
    after_id(1, 2, 1);
    send_id(6'd7);
    after_id(1, 1, 1);
    send_id(6'd9);
    after_id(1, 0, 0);

    // Fill to DEPTH, overflow drop, drain with wrap
    send_cmd(8'h81, 1, 1);
    send_cmd(8'h82, 1, 2);
    send_cmd(8'h83, 1, 3);
    chk("not_full_3", q_full, 0);
    send_cmd(8'h84, 1, 4);
    chk("full_4", q_full, 1);
    send_cmd(8'h85, 1, 4);
    chk("full_after_drop", q_full, 1);
    send_id(6'd1);
    after_id(1, 3, 1);
    send_id(6'd2);
    after_id(1, 2, 1);
    send_id(6'd3);
    after_id(1, 1, 1);
    send_id(6'd5);
    after_id(0, 1, 1);
    send_id(6'd4);
    after_id(1, 0, 0);

    // SKIP on empty queue has no effect
    send_cmd(8'hC0, 0, 0);

    // Simultaneous STOP and ID_vld in transit
    send_cmd(8'h4A, 1, 1);
    cmd = 8'h00;
    cmd_rdy = 1'b1;
    ID = 6'd10;
    ID_vld = 1'b1;
    @(negedge clk);
    chk("sim_clr_cmd", clr_cmd_rdy, 1);
    chk("sim_clr_id_wait", clr_ID_vld, 0);
    chk("sim_in_transit", in_transit, 0);
    chk("sim_q_count", q_count, 0);
    cmd_rdy = 1'b0;
    @(negedge clk);
    chk("sim_clr_id_late", clr_ID_vld, 1);
    chk("sim_no_arrive", arrived, 0);
    ID_vld = 1'b0;
    @(negedge clk);
    chk("sim_no_arrive2", arrived, 0);
    chk("sim_idle", in_transit, 0);

    // Blocked transit: buzzer and go
    OK2Move = 1'b0;
    send_cmd(8'h54, 1, 1);
    chk("blocked_go", go, 0);
`ifdef CMD_QUEUE_BUZZER_EN
    toggles = 0;
    prev = buzz;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("buzz_compl", buzz_n, ~buzz);
      if (buzz !== prev) toggles++;
      prev = buzz;
    end
    chk("buzz_toggles", (toggles >= 3) ? 1 : 0, 1);
`else
    toggles = 0;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (buzz !== prev) toggles++;
    end
    chk("buzz_off", buzz, 0);
    chk("buzz_n_off", buzz_n, 0);
    chk("buzz_toggles_none", toggles, 0);
`endif
    OK2Move = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("clear_go", go, 1);
    chk("clear_buzz", buzz, 0);
    chk("clear_buzz_n", buzz_n, 0);

    // Reset mid-transit with two entries
    send_cmd(8'h95, 1, 2);
    rst = 1'b1;
    #1;
    chk("arst_q_count", q_count, 0);
    chk("arst_in_transit", in_transit, 0);
    chk("arst_go", go, 0);
    chk("arst_q_full", q_full, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", in_transit, 0);
    send_id(6'd20);
    after_id(0, 0, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/cmd_queue_mgr.md
# cmd_queue_mgr

Parametrised command manager for the follower robot, successor to the single-destination command FSM. It accepts opcode+destination commands from the BLE112 UART path, holds up to DEPTH pending station IDs in a FIFO, and drives the motion controller `go`, the proximity-sensor enable `in_transit` and an optional piezo buzzer. It matches station IDs from the barcode (BC) unit against the queue head and advances through the route without host intervention.

## Interface

- `ID_W`, 6: station ID width in bits; command width is `ID_W+2`.
- `DEPTH`, 4: destination FIFO depth; power of 2, ≥2.
- `BUZZ_HALF`, 12500: buzzer half-period in clk cycles; 2 kHz at 50 MHz.

- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd`  in  ID_W+2  `[ID_W+1:ID_W]` opcode, `[ID_W-1:0]` destination ID.
- `cmd_rdy`  in  1  command valid, held high until `clr_cmd_rdy`.
- `ID`  in  ID_W  station ID from the BC unit.
- `ID_vld`  in  1  ID valid, held high until `clr_ID_vld`.
- `OK2Move`  in  1  proximity sensor reports the path is clear.
- `clr_cmd_rdy`  out  1  one-cycle pulse acknowledging a command.
- `clr_ID_vld`  out  1  one-cycle pulse acknowledging an ID.
- `go`  out  1  move enable to the motion controller.
- `in_transit`  out  1  enable to the proximity sensor.
- `arrived`  out  1  one-cycle pulse when a queued destination is reached.
- `q_count`  out  $clog2(DEPTH+1)  number of queued entries.
- `q_full`  out  1  `q_count == DEPTH`.
- `buzz`, `buzz_n`  out  1 each  piezo drive pair.

## Operation

- **Opcodes**
  - `00` STOP: flush the queue and go to IDLE.
  - `01` GOTO: flush the queue, enqueue the destination as the only entry, go to TRANSIT.
  - `10` APPEND: enqueue the destination. If the queue is full, the command is dropped, still acknowledged, and the queue is unchanged. From IDLE, a successful append goes to TRANSIT.
  - `11` SKIP: pop the head. Go to IDLE if the queue becomes empty. A SKIP on an empty queue has no effect.
- **States**
  - **IDLE:** `in_transit` = 0. Commands are accepted here.
  - **TRANSIT:** `in_transit` = 1. Commands are accepted here. On `ID_vld` with no `cmd_rdy` in the same cycle: capture `ID`, pulse `clr_ID_vld`, go to MATCH.
  - **MATCH:** single cycle. If the captured ID equals the head, pop the head and pulse `arrived`; go to IDLE if the queue is now empty, otherwise to TRANSIT. On a mismatch, return to TRANSIT.
- **Other `ID_vld` rules**
  - In IDLE, `ID_vld` is acknowledged but its value is discarded.
  - In MATCH, `cmd_rdy` and `ID_vld` are not sampled; both wait.
- **Simultaneous `cmd_rdy` and `ID_vld`:** the command wins. `ID_vld` stays pending and is serviced on a later cycle.
- **Re-sample guard:** `cmd_rdy` or `ID_vld` high during its own clear pulse is ignored, which prevents double processing.
- **Datapath**
  - Queue is a circular FIFO. Read/write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `q_count` is a separate counter.
  - `go = OK2Move & in_transit`, combinational.
- **Reset values:** state IDLE, queue empty, `q_count` = 0, and every output = 0.

## Timing

- `cmd_rdy` sampled high at edge n. At n+1 the state, queue and `q_count` are updated and `clr_cmd_rdy` is high for exactly one cycle.
- `in_transit` is registered, so it rises at n+1 after an accepted GOTO/APPEND, and `go` follows in the same cycle if `OK2Move`.
- ID path:
  - `ID_vld` sampled at n → `clr_ID_vld` at n+1, MATCH at n+1.
  - On a match, `arrived` pulses and the pop occurs at n+2.
  - If the queue empties, `in_transit` falls at n+2.
- Assertion of `rst` at any time asynchronously empties the queue and clears all outputs. Any in-flight command or ID is lost and is not acknowledged.

## Configuration

- `CMD_QUEUE_BUZZER_EN` defined:
  - While `in_transit & ~OK2Move`, a counter toggles `buzz` every BUZZ_HALF cycles, with `buzz_n = ~buzz`.
  - Otherwise the counter is held at 0 and `buzz` = `buzz_n` = 0.
- Not defined: no counter is built and `buzz` = `buzz_n` = 0 constantly.

## Test plan

- Reset, then GOTO 5 (`cmd=8'h45`), then `ID_vld` with ID=5, `OK2Move`=1 → `clr_cmd_rdy` one cycle; `in_transit` and `go` high; `arrived` pulse; `in_transit` low 2 cycles after `ID_vld`; `q_count` 0.
- From IDLE, APPEND 3, 7, 9 → transit starts after the first append, `q_count`=3. IDs 4, 3, 7, 9 in turn → no pop on 4, then 3 arrivals, `q_count` 2→1→0, then IDLE.
- DEPTH=4: APPEND five entries → `q_full`=1 after the 4th, the 5th is acknowledged but dropped, `q_count`=4. Drain with IDs → the read pointer wraps, FIFO order is preserved.
- `cmd_rdy` (STOP) and `ID_vld` asserted in the same cycle while in TRANSIT → STOP processed, queue flushed, IDLE, `ID_vld` acknowledged 2+ cycles later with no `arrived`.
- With `CMD_QUEUE_BUZZER_EN`, BUZZ_HALF=4, in transit, `OK2Move`=0 → `buzz` toggles every 4 cycles, `buzz_n` complementary, `go`=0. With `OK2Move`=1 → both buzzer outputs 0, `go`=1.
- `rst` pulsed mid-transit with `q_count`=2 → all outputs 0 immediately, `q_count` 0, state IDLE after release.
